// File: rtl/mult8_seq_ctrl_pkg.sv
// rtl/mult8_seq_ctrl_pkg.sv - shared types and constants for the sequential 8x8 multiplier
package mult_seq_pkg;

  // Widths
  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  // Step index: which nibble pair is fed to the core this cycle
  localparam logic [1:0] STEP_LL   = 2'd0;
  localparam logic [1:0] STEP_LH   = 2'd1;
  localparam logic [1:0] STEP_HL   = 2'd2;
  localparam logic [1:0] STEP_HH   = 2'd3;
  localparam logic [1:0] LAST_STEP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// rtl/mult8_seq_ctrl_if.sv - request/result handshake bundle for mult8_seq_ctrl
interface mult8_seq_ctrl_if #(
  parameter int TAG_W = 4
);
  import mult_seq_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_a;
  logic [OP_W-1:0]     in_b;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   out_p;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;

  // Multiplier side
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, busy
  );

  // Request source / result consumer side
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, busy
  );

endinterface

// File: rtl/mult8_seq_ctrl_mul4.sv
// rtl/mult8_seq_ctrl_mul4.sv - combinational 4x4 unsigned array multiplier core
module four_x_four_Multiplier
  import mult_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  // Sum of AND-gated rows, each row shifted by its multiplier bit position
  always_comb begin
    p = '0;
    for (int i = 0; i < NIB_W; i++) begin
      p = p + ({{NIB_W{1'b0}}, (a & {NIB_W{b[i]}})} << i);
    end
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 product over four cycles through one 4x4 core
module mult8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  mult8_seq_ctrl_if.slave   bus
);

  state_e              state_q, state_d;
  logic [1:0]          step_q, step_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [PROD_W-1:0]   out_p_q, out_p_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic                out_valid_q, out_valid_d;

  logic [NIB_W-1:0]    nib_a;
  logic [NIB_W-1:0]    nib_b;
  logic [2*NIB_W-1:0]  pp;
  logic [PROD_W-1:0]   pp_shifted;
  logic [PROD_W-1:0]   acc_sum;
  logic                in_ready_c;
  logic                accept;

  four_x_four_Multiplier u_core (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  // Nibble selection and partial-product alignment for the current step
  always_comb begin
    nib_a      = a_q[NIB_W-1:0];
    nib_b      = b_q[NIB_W-1:0];
    pp_shifted = {{(PROD_W-2*NIB_W){1'b0}}, pp};
    case (step_q)
      STEP_LL: begin
        nib_a      = a_q[NIB_W-1:0];
        nib_b      = b_q[NIB_W-1:0];
        pp_shifted = {{(PROD_W-2*NIB_W){1'b0}}, pp};
      end
      STEP_LH: begin
        nib_a      = a_q[NIB_W-1:0];
        nib_b      = b_q[OP_W-1:NIB_W];
        pp_shifted = {{(PROD_W-2*NIB_W-4){1'b0}}, pp, 4'b0};
      end
      STEP_HL: begin
        nib_a      = a_q[OP_W-1:NIB_W];
        nib_b      = b_q[NIB_W-1:0];
        pp_shifted = {{(PROD_W-2*NIB_W-4){1'b0}}, pp, 4'b0};
      end
      default: begin
        nib_a      = a_q[OP_W-1:NIB_W];
        nib_b      = b_q[OP_W-1:NIB_W];
        pp_shifted = {pp, 8'b0};
      end
    endcase
  end

  assign acc_sum = acc_q + pp_shifted;

  // Ready: always in IDLE, follows the consumer in DONE, never during reset
  always_comb begin
    in_ready_c = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    in_ready_c = 1'b1;
        DONE:    in_ready_c = bus.out_ready;
        default: in_ready_c = 1'b0;
      endcase
    end
  end

  // Next-state, step/accumulate and result capture
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    out_p_d     = out_p_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        accept = bus.in_valid;
      end
      MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) begin
          out_p_d     = acc_sum;
          out_tag_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          accept      = bus.in_valid;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new request restarts the sequence from the low nibble pair
    if (accept) begin
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      tag_d   = bus.in_tag;
      acc_d   = '0;
      step_d  = STEP_LL;
      state_d = MUL;
    end
  end

  // State and datapath registers; reset discards any in-flight product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= STEP_LL;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      out_p_q     <= out_p_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.busy      = (state_q == MUL);

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb/tb_mult8_seq_ctrl.sv - directed self-checking bench for mult8_seq_ctrl
module tb_mult8_seq_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  mult8_seq_ctrl_if #(.TAG_W(4)) bus ();

  mult8_seq_ctrl #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a request and wait (bounded) for it to be accepted
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    logic got;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("accept_ready", {31'b0, got}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen; 0 means it never came
  task automatic wait_result(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                         input logic [15:0] exp, input string nm);
    int lat;
    bus.out_ready = 1'b1;
    send(a, b, t);
    wait_result(lat);
    check_eq({nm, "_lat"}, lat, 32'd4);
    check_eq({nm, "_p"}, {16'b0, bus.out_p}, {16'b0, exp});
    check_eq({nm, "_tag"}, {28'b0, bus.out_tag}, {28'b0, t});
    @(posedge clk);
    #1;
    check_eq({nm, "_drop"}, {31'b0, bus.out_valid}, 32'd0);
  endtask

  logic [7:0]  b2b_a   [4];
  logic [7:0]  b2b_b   [4];
  logic [15:0] b2b_p   [4];
  logic [15:0] trace_acc [4];

  initial begin
    int lat;
    int t_prev;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    b2b_a = '{8'd3, 8'd200, 8'd17, 8'd128};
    b2b_b = '{8'd4, 8'd100, 8'd15, 8'd2};
    b2b_p = '{16'd12, 16'd20000, 16'd255, 16'd256};
    trace_acc = '{16'd143, 16'd2255, 16'd4335, 16'd35055};

    // Reset state
    #2;
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("rst_out_p", {16'b0, bus.out_p}, 32'd0);
    check_eq("rst_out_tag", {28'b0, bus.out_tag}, 32'd0);
    check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Basic product
    run_one(8'd13, 8'd11, 4'd3, 16'd143, "basic");

    // Accumulator trace
    bus.out_ready = 1'b1;
    send(8'hAB, 8'hCD, 4'd4);
    check_eq("trace_busy", {31'b0, bus.busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("trace_acc%0d", k), {16'b0, dut.acc_q}, {16'b0, trace_acc[k]});
    end
    check_eq("trace_valid", {31'b0, bus.out_valid}, 32'd1);
    check_eq("trace_p", {16'b0, bus.out_p}, 32'd35055);
    @(posedge clk);
    #1;

    // Corners
    run_one(8'd255, 8'd255, 4'd7, 16'd65025, "max");
    run_one(8'd0, 8'd200, 4'd8, 16'd0, "zero");
    run_one(8'd1, 8'd1, 4'd9, 16'd1, "one");

    // Backpressure
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, 4'd5);
    wait_result(lat);
    check_eq("bp_lat", lat, 32'd4);
    bus.in_a   = 8'd99;
    bus.in_b   = 8'd77;
    bus.in_tag = 4'd15;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check_eq("bp_p", {16'b0, bus.out_p}, 32'd936);
      check_eq("bp_tag", {28'b0, bus.out_tag}, 32'd5);
      check_eq("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_a      = 8'd3;
    bus.in_b      = 8'd5;
    bus.in_tag    = 4'd6;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("bp_handoff_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("bp_handoff_busy", {31'b0, bus.busy}, 32'd1);
    wait_result(lat);
    check_eq("bp_next_lat", lat, 32'd4);
    check_eq("bp_next_p", {16'b0, bus.out_p}, 32'd15);
    check_eq("bp_next_tag", {28'b0, bus.out_tag}, 32'd6);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid and out_ready held high
    bus.out_ready = 1'b1;
    bus.in_a      = b2b_a[0];
    bus.in_b      = b2b_b[0];
    bus.in_tag    = 4'd0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check_eq("b2b_ready0", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_a   = b2b_a[1];
    bus.in_b   = b2b_b[1];
    bus.in_tag = 4'd1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_result(lat);
      check_eq($sformatf("b2b_lat%0d", i), lat, 32'd4);
      check_eq($sformatf("b2b_p%0d", i), {16'b0, bus.out_p}, {16'b0, b2b_p[i]});
      check_eq($sformatf("b2b_tag%0d", i), {28'b0, bus.out_tag}, i);
      if (i > 0) check_eq($sformatf("b2b_gap%0d", i), cyc - t_prev, 32'd5);
      t_prev = cyc;
      if (i < 3) begin
        @(posedge clk);
        #1;
        check_eq($sformatf("b2b_busy%0d", i), {31'b0, bus.busy}, 32'd1);
        if (i + 2 <= 3) begin
          bus.in_a   = b2b_a[i + 2];
          bus.in_b   = b2b_b[i + 2];
          bus.in_tag = 4'(i + 2);
        end else begin
          bus.in_valid = 1'b0;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("b2b_idle_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("b2b_idle_busy", {31'b0, bus.busy}, 32'd0);

    // Reset during step 2 of 100*100
    bus.out_ready = 1'b1;
    send(8'd100, 8'd100, 4'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("mid_step", {30'b0, dut.step_q}, 32'd2);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_p", {16'b0, bus.out_p}, 32'd0);
    check_eq("mid_rst_ready", {31'b0, bus.in_ready}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid2", {31'b0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_ready2", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    run_one(8'd7, 8'd9, 4'd2, 16'd63, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
